// File: rtl/dma_mem_responder_pkg.sv
// dma_pkg: shared FSM state type, response codes and minimum burst length for the DMA memory responder.
package dma_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;
    localparam int   MIN_LEN  = 1;
endpackage

// File: rtl/dma_mem_responder_if.sv
// dma_mem_responder_if: command, write-data, read-data and completion channels between the DMA initiator and a memory responder.
//   master = DMA initiator side, slave = memory responder side.
interface dma_mem_responder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  resp_valid;
    logic                  resp_err;
    modport master (
        output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last, resp_valid, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last, resp_valid, resp_err
    );
endinterface

// File: rtl/dma_resp_mem.sv
// dma_resp_mem: single-port synchronous RAM with a registered 1-cycle read; the read register holds its value until the next read.
//   clk, reset : clock and synchronous active-high reset (clears only the read register)
//   i_we/i_re  : write / read strobes (never both at once), i_addr: word address
//   i_wdata    : write word, o_rdata: registered read word
//   i_wpar/o_rpar : stored parity bit, present only with DMA_RESP_PARITY_EN
module dma_resp_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
`ifdef DMA_RESP_PARITY_EN
    input  logic                  i_wpar,
    output logic                  o_rpar,
`endif
    output logic [DATA_WIDTH-1:0] o_rdata
);
`ifdef DMA_RESP_PARITY_EN
    localparam int W = DATA_WIDTH + 1;
`else
    localparam int W = DATA_WIDTH;
`endif
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_q;
    logic [W-1:0] w_wdata;
`ifdef DMA_RESP_PARITY_EN
    assign w_wdata = {i_wpar, i_wdata};
    assign o_rpar  = r_q[DATA_WIDTH];
`else
    assign w_wdata = i_wdata;
`endif
    assign o_rdata = r_q[DATA_WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= w_wdata;
    end
    always_ff @(posedge clk) begin
        if (reset) r_q <= '0;
        else if (i_re) r_q <= r_mem[i_addr];
    end
endmodule

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: memory-side target answering DMA burst read/write commands from an internal RAM.
//   clk, reset       : clock, synchronous active-high reset (outputs low, state IDLE, memory kept)
//   bus (slave)      : command / write-data / read-data / completion channels, valid-ready handshakes
//   o_busy           : high whenever the FSM is not IDLE
//   i_inject_par_err : test input, flips the stored parity of the next write beat (DMA_RESP_PARITY_EN only)
// Optional feature macro: DMA_RESP_PARITY_EN (per-word even parity, checked on every read beat).
module dma_mem_responder
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic clk,
    input  logic reset,
    dma_mem_responder_if.slave bus,
    output logic o_busy
`ifdef DMA_RESP_PARITY_EN
    ,
    input  logic i_inject_par_err
`endif
);
    state_t                r_state;
    logic                  r_req_ready, r_wr_ready, r_rd_valid, r_rd_last;
    logic                  r_resp_valid, r_resp_err, r_busy, r_par_err;
    logic [ADDR_WIDTH-1:0] r_ptr, r_left;
    logic [ADDR_WIDTH:0]   w_end;
    logic                  w_len_err, w_req_fire, w_wr_fire, w_rd_fire, w_rd_start, w_rd_issue, w_par_bad;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_end      = {1'b0, bus.req_addr} + {1'b0, bus.req_len};
    assign w_len_err  = ({1'b0, bus.req_len} < (ADDR_WIDTH+1)'(MIN_LEN)) || (w_end > (ADDR_WIDTH+1)'(DEPTH));
    assign w_req_fire = bus.req_valid && r_req_ready;
    assign w_wr_fire  = bus.wr_valid && r_wr_ready;
    assign w_rd_fire  = r_rd_valid && bus.rd_ready;
    // The first read is issued on the accept edge so the first beat shows one cycle after accept.
    assign w_rd_start = w_req_fire && !bus.req_write && !w_len_err;
    // Refill the output register when it is empty or being drained this cycle.
    assign w_rd_issue = (r_state == READ) && (r_left != '0) && (!r_rd_valid || bus.rd_ready);
    assign w_mem_addr = (r_state == IDLE) ? bus.req_addr : r_ptr;

`ifdef DMA_RESP_PARITY_EN
    logic r_inj, w_rd_par;
    always_ff @(posedge clk) begin
        if (reset) r_inj <= 1'b0;
        else if (w_wr_fire) r_inj <= 1'b0;
        else if (i_inject_par_err) r_inj <= 1'b1;
    end
    assign w_par_bad = w_rd_fire && ((^w_rd_data) != w_rd_par);
`else
    assign w_par_bad = 1'b0;
`endif

    dma_resp_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr_fire),
        .i_re    (w_rd_start || w_rd_issue),
        .i_addr  (w_mem_addr),
        .i_wdata (bus.wr_data),
`ifdef DMA_RESP_PARITY_EN
        .i_wpar  ((^bus.wr_data) ^ (r_inj | i_inject_par_err)),
        .o_rpar  (w_rd_par),
`endif
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_wr_ready   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= RESP_OK;
            r_busy       <= 1'b0;
            r_par_err    <= 1'b0;
            r_ptr        <= '0;
            r_left       <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_req_fire) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_par_err   <= 1'b0;
                        r_resp_err  <= w_len_err ? RESP_ERR : RESP_OK;
                        if (w_len_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                        end else if (bus.req_write) begin
                            r_state    <= WRITE;
                            r_wr_ready <= 1'b1;
                            r_ptr      <= bus.req_addr;
                            r_left     <= bus.req_len;
                        end else begin
                            r_state    <= READ;
                            r_rd_valid <= 1'b1;
                            r_rd_last  <= (bus.req_len == ADDR_WIDTH'(1));
                            r_ptr      <= bus.req_addr + ADDR_WIDTH'(1);
                            r_left     <= bus.req_len - ADDR_WIDTH'(1);
                        end
                    end
                end
                WRITE: begin
                    if (w_wr_fire) begin
                        r_ptr  <= r_ptr + ADDR_WIDTH'(1);
                        r_left <= r_left - ADDR_WIDTH'(1);
                        if (r_left == ADDR_WIDTH'(1)) begin
                            r_state      <= RESP;
                            r_wr_ready   <= 1'b0;
                            r_resp_valid <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_par_bad) r_par_err <= 1'b1;
                    if (w_rd_issue) begin
                        r_ptr      <= r_ptr + ADDR_WIDTH'(1);
                        r_left     <= r_left - ADDR_WIDTH'(1);
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= (r_left == ADDR_WIDTH'(1));
                    end else if (w_rd_fire) begin
                        r_rd_valid <= 1'b0;
                        if (r_rd_last) begin
                            r_rd_last    <= 1'b0;
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= (r_par_err || w_par_bad) ? RESP_ERR : RESP_OK;
                        end
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_resp_err  <= RESP_OK;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.wr_ready   = r_wr_ready;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = w_rd_data;
    assign bus.rd_last    = r_rd_last;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign o_busy         = r_busy;
endmodule
